// File: rtl/ray_tracer_scheduler.sv
// Sweeps every sphere in the object store for one ray, 3 cycles per object, and reports the nearest hit.
// Ray accepted only in IDLE; the result is held in DONE until result_ready.
module ray_tracer_scheduler #(
  parameter int unsigned NUM_OBJ  = 8,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [27:0] ray_init,
  input  logic [30:0] ray_dir,
  output logic [3:0]  obj_addr,
  input  logic [47:0] obj_data,
  output logic [27:0] trc_init,
  output logic [30:0] trc_dir,
  output logic [47:0] trc_object,
  input  logic [9:0]  trc_t,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [11:0] result_color,
  output logic [9:0]  result_t,
  output logic        result_hit,
  output logic [3:0]  result_idx
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EVAL, S_DONE} state_t;

  localparam logic [9:0] MISS_T   = 10'h3FF;
  localparam logic [3:0] LAST_IDX = 4'(NUM_OBJ - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [27:0] init_q, init_d;
  logic [30:0] dir_q, dir_d;
  logic [47:0] obj_q, obj_d;
  logic [9:0]  best_t_q, best_t_d;
  logic [11:0] best_color_q, best_color_d;
  logic        best_hit_q, best_hit_d;
  logic [3:0]  best_idx_q, best_idx_d;
  logic        closer;

  // Strict less-than keeps the lowest index on equal distances.
  assign closer = (trc_t != MISS_T) && (obj_q[35:28] != 8'd0) && (trc_t < best_t_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    init_d       = init_q;
    dir_d        = dir_q;
    obj_d        = obj_q;
    best_t_d     = best_t_q;
    best_color_d = best_color_q;
    best_hit_d   = best_hit_q;
    best_idx_d   = best_idx_q;
    ray_ready    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) begin
          init_d       = ray_init;
          dir_d        = ray_dir;
          idx_d        = 4'd0;
          best_t_d     = MISS_T;
          best_color_d = BG_COLOR;
          best_hit_d   = 1'b0;
          best_idx_d   = 4'd0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        obj_d   = obj_data;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (closer) begin
          best_t_d     = trc_t;
          best_color_d = obj_q[47:36];
          best_idx_d   = idx_q;
          best_hit_d   = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      init_q       <= 28'd0;
      dir_q        <= 31'd0;
      obj_q        <= 48'd0;
      best_t_q     <= MISS_T;
      best_color_q <= BG_COLOR;
      best_hit_q   <= 1'b0;
      best_idx_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      init_q       <= init_d;
      dir_q        <= dir_d;
      obj_q        <= obj_d;
      best_t_q     <= best_t_d;
      best_color_q <= best_color_d;
      best_hit_q   <= best_hit_d;
      best_idx_q   <= best_idx_d;
    end
  end

  // idx only changes when entering FETCH, so it doubles as the held read address.
  assign obj_addr     = idx_q;
  assign trc_init     = init_q;
  assign trc_dir      = dir_q;
  assign trc_object   = obj_q;
  assign result_color = best_color_q;
  assign result_t     = best_t_q;
  assign result_hit   = best_hit_q;
  assign result_idx   = best_idx_q;

endmodule

// File: tb/tb_ray_tracer_scheduler.sv
// Bench for ray_tracer_scheduler: object store with 1-cycle read, sphere unit returning t from the
// sphere's low center bits, and a nearest-hit reference model over the store contents.
module tb_ray_tracer_scheduler;

  localparam int          N  = 4;
  localparam logic [11:0] BG = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ray_valid = 1'b0;
  logic        ray_ready;
  logic [27:0] ray_init = '0;
  logic [30:0] ray_dir = '0;
  logic [3:0]  obj_addr;
  logic [47:0] obj_data = '0;
  logic [27:0] trc_init;
  logic [30:0] trc_dir;
  logic [47:0] trc_object;
  logic [9:0]  trc_t;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [11:0] result_color;
  logic [9:0]  result_t;
  logic        result_hit;
  logic [3:0]  result_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cnt = 0;
  logic [47:0] mem [16];

  ray_tracer_scheduler #(.NUM_OBJ(N), .BG_COLOR(BG)) dut (
    .clk(clk), .rst_n(rst_n), .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_init(ray_init), .ray_dir(ray_dir), .obj_addr(obj_addr), .obj_data(obj_data),
    .trc_init(trc_init), .trc_dir(trc_dir), .trc_object(trc_object), .trc_t(trc_t),
    .result_valid(result_valid), .result_ready(result_ready), .result_color(result_color),
    .result_t(result_t), .result_hit(result_hit), .result_idx(result_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && ray_valid && ray_ready) acc_cnt <= acc_cnt + 1;
  always @(posedge clk) obj_data <= mem[obj_addr];
  assign trc_t = trc_object[9:0];

  task automatic set_obj(input int i, input logic [11:0] color, input logic [7:0] r, input logic [9:0] t);
    mem[i] = {color, r, 18'($urandom), t};
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++)
      set_obj(i, 12'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
              ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 31)));
  endtask

  // Nearest sphere with nonzero radius; first one wins on equal distance.
  function automatic logic [26:0] model();
    logic [9:0] bt = 10'h3FF;
    logic [11:0] bc = BG;
    logic [3:0] bi = 4'd0;
    logic bh = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mem[i][35:28] != 8'd0 && mem[i][9:0] != 10'h3FF && mem[i][9:0] < bt) begin
        bt = mem[i][9:0]; bc = mem[i][47:36]; bi = 4'(i); bh = 1'b1;
      end
    end
    return {bh, bi, bt, bc};
  endfunction

  function automatic logic [26:0] res_now();
    return {result_hit, result_idx, result_t, result_color};
  endfunction

  task automatic send_ray(input logic [27:0] o, input logic [30:0] d, output int acc, output bit to);
    bit rdy;
    ray_init = o; ray_dir = d; ray_valid = 1'b1; to = 1'b1; acc = 0;
    for (int k = 0; k < 200; k++) begin
      rdy = ray_ready;
      @(posedge clk); #1;
      if (rdy) begin to = 1'b0; acc = cyc; break; end
    end
    ray_valid = 1'b0;
  endtask

  task automatic do_ray(input logic [27:0] o, input logic [30:0] d, output int lat, output int rlat,
                        output logic [26:0] res, output bit stable, output logic [3:0] addr0);
    int acc; bit to; logic saved;
    stable = 1'b1; lat = -1; rlat = -1; res = '0; addr0 = 4'hF;
    send_ray(o, d, acc, to);
    if (to) return;
    addr0 = obj_addr;
    for (int k = 0; k < 100 && !result_valid; k++) begin
      if (trc_init !== o || trc_dir !== d) stable = 1'b0;
      @(posedge clk); #1;
    end
    if (!result_valid) return;
    lat = cyc - acc;
    res = res_now();
    saved = result_ready;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = saved;
    if (ray_ready) rlat = cyc - acc;
  endtask

  task automatic test_reset();
    logic [26:0] exp_r;
    #1 rst_n = 1'b0;
    #2;
    exp_r = {1'b0, 4'd0, 10'h3FF, BG};
    n_cmp++;
    if ({ray_ready, result_valid, obj_addr, trc_init, trc_dir, trc_object} !== {1'b1, 1'b0, 4'd0, 28'd0, 31'd0, 48'd0}) begin
      n_err++; $display("FAIL reset_ctrl: got rdy=%b vld=%b addr=%0d init=%h dir=%h obj=%h, want 1 0 0 0 0 0",
                        ray_ready, result_valid, obj_addr, trc_init, trc_dir, trc_object);
    end
    n_cmp++;
    if (res_now() !== exp_r) begin n_err++; $display("FAIL reset_result: got %h want %h", res_now(), exp_r); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_all_miss();
    int lat, rlat; logic [26:0] res; bit st; logic [3:0] a0;
    for (int i = 0; i < N; i++) set_obj(i, 12'($urandom), 8'd9, 10'h3FF);
    do_ray(28'h1234567, 31'h0ABCDEF, lat, rlat, res, st, a0);
    n_cmp++;
    if (lat !== 3 * N) begin n_err++; $display("FAIL miss_latency: got %0d want %0d", lat, 3 * N); end
    n_cmp++;
    if (res !== {1'b0, 4'd0, 10'h3FF, BG}) begin n_err++; $display("FAIL miss_result: got %h want %h", res, {1'b0, 4'd0, 10'h3FF, BG}); end
    n_cmp++;
    if (a0 !== 4'd0) begin n_err++; $display("FAIL miss_addr0: got %0d want 0", a0); end
  endtask

  task automatic test_tie();
    int lat, rlat; logic [26:0] res; bit st; logic [3:0] a0;
    set_obj(0, 12'hAAA, 8'd10, 10'd50);
    set_obj(1, 12'hBBB, 8'd10, 10'd20);
    set_obj(2, 12'hCCC, 8'd10, 10'd20);
    set_obj(3, 12'hDDD, 8'd10, 10'd90);
    do_ray(28'h0F0F0F0, 31'h1234321, lat, rlat, res, st, a0);
    n_cmp++;
    if (res !== {1'b1, 4'd1, 10'd20, 12'hBBB}) begin n_err++; $display("FAIL tie_result: got %h want %h", res, {1'b1, 4'd1, 10'd20, 12'hBBB}); end
  endtask

  task automatic test_zero_radius();
    int lat, rlat; logic [26:0] res; bit st; logic [3:0] a0;
    set_obj(0, 12'h111, 8'd3, 10'd40);
    set_obj(1, 12'h222, 8'd3, 10'd40);
    set_obj(2, 12'h333, 8'd0, 10'd5);
    set_obj(3, 12'h444, 8'd3, 10'd40);
    do_ray(28'h0000001, 31'h0000002, lat, rlat, res, st, a0);
    n_cmp++;
    if (res !== {1'b1, 4'd0, 10'd40, 12'h111}) begin n_err++; $display("FAIL zero_r_result: got %h want %h", res, {1'b1, 4'd0, 10'd40, 12'h111}); end
  endtask

  task automatic test_stall();
    int acc, base, k; bit to; logic [26:0] held, exp_r;
    rand_mem();
    exp_r = model();
    send_ray(28'hABCDEF0, 31'h7654321, acc, to);
    ray_valid = 1'b1;
    for (k = 0; k < 100 && !result_valid; k++) begin @(posedge clk); #1; end
    held = res_now();
    n_cmp++;
    if (!result_valid || held !== exp_r) begin n_err++; $display("FAIL stall_result: vld=%b got %h want %h", result_valid, held, exp_r); end
    base = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({result_valid, ray_ready, res_now()} !== {1'b1, 1'b0, exp_r}) begin
        n_err++; $display("FAIL stall_hold[%0d]: vld=%b rdy=%b res=%h want 1 0 %h", i, result_valid, ray_ready, res_now(), exp_r);
      end
    end
    result_ready = 1'b1;
    ray_init = 28'h5555555; ray_dir = 31'h2AAAAAA;
    @(posedge clk); #1;
    result_ready = 1'b0;
    n_cmp++;
    if ({ray_ready, result_valid, acc_cnt - base} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++; $display("FAIL stall_release: rdy=%b vld=%b acc=%0d want 1 0 0", ray_ready, result_valid, acc_cnt - base);
    end
    repeat (6) begin @(posedge clk); #1; end
    ray_valid = 1'b0;
    n_cmp++;
    if (acc_cnt - base !== 1 || trc_init !== 28'h5555555) begin
      n_err++; $display("FAIL stall_accepts: got %0d init=%h want 1 5555555", acc_cnt - base, trc_init);
    end
    for (k = 0; k < 100 && !result_valid; k++) begin @(posedge clk); #1; end
    n_cmp++;
    if (!result_valid || res_now() !== exp_r) begin n_err++; $display("FAIL stall_second: got %h want %h", res_now(), exp_r); end
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc, lat, rlat; bit to, st; logic [26:0] res, exp_r; logic [3:0] a0;
    for (int i = 0; i < N; i++) set_obj(i, 12'hE00 + 12'(i), 8'd7, 10'd10 + 10'(i));
    send_ray(28'h3333333, 31'h4444444, acc, to);
    repeat (8) begin @(posedge clk); #1; end
    n_cmp++;
    if ({obj_addr, ray_ready, result_hit} !== {4'd2, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL mid_progress: addr=%0d rdy=%b hit=%b want 2 0 1", obj_addr, ray_ready, result_hit);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ray_ready, result_valid, obj_addr, trc_init, trc_dir, trc_object, res_now()} !==
        {1'b1, 1'b0, 4'd0, 28'd0, 31'd0, 48'd0, 1'b0, 4'd0, 10'h3FF, BG}) begin
      n_err++; $display("FAIL mid_async_reset: rdy=%b vld=%b addr=%0d init=%h obj=%h res=%h",
                        ray_ready, result_valid, obj_addr, trc_init, trc_object, res_now());
    end
    @(posedge clk); #1 rst_n = 1'b1;
    rand_mem();
    exp_r = model();
    do_ray(28'h0777777, 31'h0666666, lat, rlat, res, st, a0);
    n_cmp++;
    if ({lat, a0, res} !== {3 * N, 4'd0, exp_r}) begin
      n_err++; $display("FAIL mid_next_ray: lat=%0d addr0=%0d res=%h want %0d 0 %h", lat, a0, res, 3 * N, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rlat; logic [26:0] res, exp_r; bit st; logic [3:0] a0;
    result_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rand_mem();
      exp_r = model();
      do_ray(28'($urandom), 31'($urandom), lat, rlat, res, st, a0);
      n_cmp++;
      if ({lat, rlat, st, res} !== {3 * N, 3 * N + 1, 1'b1, exp_r}) begin
        n_err++; $display("FAIL b2b[%0d]: lat=%0d rlat=%0d stable=%b res=%h want %0d %0d 1 %h",
                          r, lat, rlat, st, res, 3 * N, 3 * N + 1, exp_r);
      end
    end
    result_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, rlat; logic [26:0] res, exp_r; bit st; logic [3:0] a0;
    for (int r = 0; r < 10; r++) begin
      rand_mem();
      exp_r = model();
      do_ray(28'($urandom), 31'($urandom), lat, rlat, res, st, a0);
      n_cmp++;
      if ({lat, st, res} !== {3 * N, 1'b1, exp_r}) begin
        n_err++; $display("FAIL random[%0d]: lat=%0d stable=%b res=%h want %0d 1 %h", r, lat, st, res, 3 * N, exp_r);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_all_miss();
    test_tie();
    test_zero_radius();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ray_tracer_scheduler.md
RAY_TRACER_SCHEDULER -- requirements
Module: ray_tracer_scheduler

Interface
REQ-001 Parameter NUM_OBJ, default 8, number of sphere entries in the object store (1..16).
REQ-002 Parameter BG_COLOR, default 12'h000, color returned when no sphere is hit.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ray_valid  input  1  a new ray is offered on ray_init/ray_dir.
REQ-006 ray_ready  output  1  scheduler can accept a ray.
REQ-007 ray_init  input  28  ray origin, packed 10/10/8 (x/y/z).
REQ-008 ray_dir  input  31  ray direction, packed 11/11/9 signed.
REQ-009 obj_addr  output  4  object-store read address.
REQ-010 obj_data  input  48  object-store read data {color[11:0], r[7:0], center[27:0]}, valid one cycle after obj_addr.
REQ-011 trc_init  output  28  origin driven to the sphere intersection unit.
REQ-012 trc_dir  output  31  direction driven to the sphere intersection unit.
REQ-013 trc_object  output  48  sphere driven to the sphere intersection unit.
REQ-014 trc_t  input  10  combinational distance from the sphere unit; 10'h3FF means miss.
REQ-015 result_valid  output  1  result fields valid.
REQ-016 result_ready  input  1  consumer takes the result.
REQ-017 result_color  output  12  color of the nearest hit, or BG_COLOR.
REQ-018 result_t  output  10  nearest distance, or 10'h3FF on miss.
REQ-019 result_hit  output  1  at least one sphere hit.
REQ-020 result_idx  output  4  index of the nearest sphere; 0 on miss.

Function
REQ-021 FSM states: IDLE, FETCH, LOAD, EVAL, DONE.
REQ-022 IDLE: ray_ready=1; on ray_valid, latch ray_init/ray_dir into trc_init/trc_dir, clear idx, set best_t=10'h3FF, best_hit=0, best_color=BG_COLOR, best_idx=0, then go to FETCH.
REQ-023 FETCH: obj_addr=idx, then go to LOAD.
REQ-024 LOAD: register obj_data into trc_object, then go to EVAL.
REQ-025 EVAL: sample trc_t; if trc_t!=10'h3FF, trc_object[35:28]!=0 and trc_t<best_t (strict), update best_t, best_color=trc_object[47:36], best_idx=idx and best_hit=1.
REQ-026 EVAL exit: if idx==NUM_OBJ-1, go to DONE; otherwise increment idx and go to FETCH.
REQ-027 Spheres with r==0 are skipped for update but still take 3 cycles.
REQ-028 Ties on trc_t keep the lowest index.
REQ-029 Throughput: exactly 3 cycles per object. result_valid rises exactly 3*NUM_OBJ cycles after the accepting edge.
REQ-030 DONE: result_valid=1 and result_* = best_*, held stable until result_ready; on result_ready, go to IDLE.
REQ-031 ray_ready is 1 only in IDLE. A ray is never accepted in DONE, even if result_ready is 1 in the same cycle.
REQ-032 trc_init, trc_dir and trc_object stay constant from latch until the next latch.
REQ-033 obj_addr holds its last value outside FETCH.
REQ-034 A ray_valid drop during processing has no effect; the ray is not re-accepted.

Reset
REQ-035 While rst_n=0, immediately and independent of clk: state=IDLE, ray_ready=1, result_valid=0, result_color=BG_COLOR, result_t=10'h3FF, result_hit=0, result_idx=0, obj_addr=0, trc_* all 0.
REQ-036 Reset asserted mid-ray abandons that ray. After rst_n rises, the first result corresponds only to a newly accepted ray.

Verification
REQ-037 NUM_OBJ=4, trc_t model returns 3FF for all objects -> result_valid at cycle 12 after accept; result_hit=0; result_t=3FF; result_color=BG_COLOR; result_idx=0.
REQ-038 trc_t per index {50,20,20,90}, colors {A,B,C,D} -> result_t=20, result_idx=1, result_color=B (tie goes to lowest index).
REQ-039 Index 2 has r=0 and model returns t=5, others return 40 -> index 2 ignored; result_t=40, result_idx=0.
REQ-040 result_ready held 0 for 10 cycles in DONE, with ray_valid=1 throughout -> result fields stable; ray_ready=0; exactly one acceptance after the return to IDLE.
REQ-041 rst_n pulsed low during EVAL of idx 2 -> outputs take reset values asynchronously; next ray completes a full 3*NUM_OBJ sweep starting at obj_addr=0.
REQ-042 Back-to-back rays with result_ready tied 1 -> each ray takes 3*NUM_OBJ+1 cycles from acceptance to the next ray_ready; trc_init/trc_dir change only on acceptance edges.
